// File: rtl/custom_sum_pipe.sv
// Sums N_IN unsigned operands per beat with optional running accumulation and saturate/wrap.
// Latency 2 cycles. Full-throughput elastic: S2 holds on !out_ready, S1 advances when S2 drains.
module custom_sum_pipe #(
    parameter int WIDTH  = 8,
    parameter int N_IN   = 4,
    parameter int OWIDTH = 12,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic                    in_acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OWIDTH-1:0]       out_res,
    output logic                    out_ovf
);
    localparam int SW = WIDTH + $clog2(N_IN);

    logic              s1_valid;
    logic [SW-1:0]     s1_sum;
    logic              s1_acc;
    logic [OWIDTH-1:0] acc_reg;

    logic              s1_adv;
    logic [SW-1:0]     tree_sum;
    logic [OWIDTH:0]   raw_sum;
    logic [OWIDTH-1:0] res_nxt;
    logic              ovf_nxt;

    // S2 is free when empty or its result is leaving this cycle.
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            tree_sum = tree_sum + SW'(in_data[k*WIDTH +: WIDTH]);
        end
    end

    // One extra bit catches overflow of accumulator plus beat sum.
    always_comb begin
        raw_sum = (s1_acc ? (OWIDTH+1)'(acc_reg) : '0) + (OWIDTH+1)'(s1_sum);
        ovf_nxt = raw_sum[OWIDTH];
        res_nxt = (ovf_nxt && SAT != 0) ? '1 : raw_sum[OWIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_acc    <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_ovf   <= 1'b0;
            acc_reg   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_sum <= tree_sum;
                s1_acc <= in_acc;
            end
            // acc_reg tracks the post-saturation result so chained beats need no bubble.
            if (s1_adv) begin
                out_valid <= 1'b1;
                out_res   <= res_nxt;
                out_ovf   <= ovf_nxt;
                acc_reg   <= res_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_custom_sum_pipe.sv
// Bench: four instances (8-bit x4 saturate/wrap, 5-bit x7 saturate/wrap) share control inputs.
module tb_custom_sum_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_acc;
    logic        out_ready;
    logic [31:0] in_data;
    logic [34:0] in_data7;

    logic [3:0]  o_vld;
    logic [3:0]  o_rdy;
    logic [3:0]  o_ovf;
    logic [11:0] res_a, res_b;
    logic [7:0]  res_c, res_d;
    logic [31:0] o_res [4];

    assign o_res[0] = 32'(res_a);
    assign o_res[1] = 32'(res_b);
    assign o_res[2] = 32'(res_c);
    assign o_res[3] = 32'(res_d);

    custom_sum_pipe #(.WIDTH(8), .N_IN(4), .OWIDTH(12), .SAT(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[0]), .in_data(in_data),
        .in_acc(in_acc), .out_valid(o_vld[0]), .out_ready(out_ready), .out_res(res_a), .out_ovf(o_ovf[0]));
    custom_sum_pipe #(.WIDTH(8), .N_IN(4), .OWIDTH(12), .SAT(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[1]), .in_data(in_data),
        .in_acc(in_acc), .out_valid(o_vld[1]), .out_ready(out_ready), .out_res(res_b), .out_ovf(o_ovf[1]));
    custom_sum_pipe #(.WIDTH(5), .N_IN(7), .OWIDTH(8), .SAT(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[2]), .in_data(in_data7),
        .in_acc(in_acc), .out_valid(o_vld[2]), .out_ready(out_ready), .out_res(res_c), .out_ovf(o_ovf[2]));
    custom_sum_pipe #(.WIDTH(5), .N_IN(7), .OWIDTH(8), .SAT(0)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[3]), .in_data(in_data7),
        .in_acc(in_acc), .out_valid(o_vld[3]), .out_ready(out_ready), .out_res(res_d), .out_ovf(o_ovf[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] e;   // bit 32 = overflow, [31:0] = result
        int          cyc;
    } sb_t;

    typedef struct {
        logic [31:0] d;
        logic        a;
        logic [11:0] rs;
        logic        os;
        logic [11:0] rw;
        logic        ow;
    } vec_t;

    localparam int P_N   [4] = '{4, 4, 7, 7};
    localparam int P_W   [4] = '{8, 8, 5, 5};
    localparam int P_OW  [4] = '{12, 12, 8, 8};
    localparam int P_SAT [4] = '{1, 0, 1, 0};

    sb_t         sbq [4][$];
    logic [31:0] acc_m [4];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cycle = 0;
    bit          chk_lat = 0;
    bit          use_tab = 0;
    logic [32:0] tab_a, tab_b;
    bit          took;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    function automatic logic [32:0] model(input int n, input int w, input int ow, input int sat,
                                          input logic [63:0] d, input logic a, input logic [31:0] accv);
        longint s;
        longint m;
        s = a ? longint'(accv) : 0;
        for (int k = 0; k < n; k++) s += longint'((d >> (k*w)) & ((64'd1 << w) - 1));
        m = longint'(1) << ow;
        if (s >= m) return {1'b1, (sat != 0) ? 32'(m - 1) : 32'(s - m)};
        return {1'b0, 32'(s)};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            sbq[i].delete();
            acc_m[i] = '0;
        end
    endtask

    // Called at a falling edge: drive, check outputs, record accepts, advance one cycle.
    task automatic cyc(input logic v, input logic [31:0] d8, input logic [34:0] d7,
                       input logic a, input logic r);
        sb_t         e;
        logic [63:0] dd;
        in_valid = v; in_data = d8; in_data7 = d7; in_acc = a; out_ready = r;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (o_vld[i] && out_ready) begin
                if (sbq[i].size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out[%0d]: got out_valid=1 expected no result (cycle %0d)", i, cycle);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("out_res[%0d]", i), o_res[i], e.e[31:0]);
                    chk($sformatf("out_ovf[%0d]", i), o_ovf[i], e.e[32]);
                    if (chk_lat) chk($sformatf("latency[%0d]", i), cycle - e.cyc, 2);
                end
            end
        end
        took = in_valid && o_rdy[0];
        for (int i = 0; i < 4; i++) begin
            if (in_valid && o_rdy[i]) begin
                dd = (i < 2) ? {32'd0, in_data} : {29'd0, in_data7};
                if (use_tab && i < 2) e.e = (i == 0) ? tab_a : tab_b;
                else e.e = model(P_N[i], P_W[i], P_OW[i], P_SAT[i], dd, in_acc, acc_m[i]);
                e.cyc = cycle;
                acc_m[i] = e.e[31:0];
                sbq[i].push_back(e);
            end
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) cyc(1'b0, 32'd0, 35'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) chk($sformatf("drained[%0d]", i), sbq[i].size(), 0);
    endtask

    initial begin
        vec_t        tab [12];
        logic [31:0] bpd [6];
        logic [11:0] held;
        logic [63:0] rnd;
        int          bi;
        int          acc_cnt;

        tab[0]  = '{32'h04030201, 1'b0, 12'd10,   1'b0, 12'd10,   1'b0};
        tab[1]  = '{32'h01010101, 1'b0, 12'd4,    1'b0, 12'd4,    1'b0};
        tab[2]  = '{32'h02020202, 1'b1, 12'd12,   1'b0, 12'd12,   1'b0};
        tab[3]  = '{32'h00000001, 1'b1, 12'd13,   1'b0, 12'd13,   1'b0};
        tab[4]  = '{32'hFFFFFFFF, 1'b0, 12'd1020, 1'b0, 12'd1020, 1'b0};
        tab[5]  = '{32'hFFFFFFFF, 1'b1, 12'd2040, 1'b0, 12'd2040, 1'b0};
        tab[6]  = '{32'hFFFFFFFF, 1'b1, 12'd3060, 1'b0, 12'd3060, 1'b0};
        tab[7]  = '{32'hFFFFFFFF, 1'b1, 12'd4080, 1'b0, 12'd4080, 1'b0};
        tab[8]  = '{32'hFFFFFFFF, 1'b1, 12'd4095, 1'b1, 12'd1004, 1'b1};
        tab[9]  = '{32'hFFFFFFFF, 1'b1, 12'd4095, 1'b1, 12'd2024, 1'b0};
        tab[10] = '{32'h00000000, 1'b1, 12'd4095, 1'b0, 12'd2024, 1'b0};
        tab[11] = '{32'hFFFFFFFF, 1'b0, 12'd1020, 1'b0, 12'd1020, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_data7 = '0; in_acc = 1'b0; out_ready = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", o_vld[0], 0);
        chk("rst_out_res", res_a, 0);
        chk("rst_out_ovf", o_ovf[0], 0);
        chk("rst_in_ready", o_rdy[0], 1);

        // Single beat: exact two-cycle latency.
        cyc(1'b1, 32'h04030201, 35'd0, 1'b0, 1'b1);
        chk("lat1_out_valid", o_vld[0], 0);
        cyc(1'b0, 32'd0, 35'd0, 1'b0, 1'b1);
        chk("lat2_out_valid", o_vld[0], 1);
        chk("lat2_out_res", res_a, 10);
        drain(3);

        // Back-to-back table vectors: accumulation chaining, saturate and wrap.
        chk_lat = 1; use_tab = 1;
        for (int i = 0; i < 12; i++) begin
            tab_a = {tab[i].os, 20'd0, tab[i].rs};
            tab_b = {tab[i].ow, 20'd0, tab[i].rw};
            cyc(1'b1, tab[i].d, 35'd0, tab[i].a, 1'b1);
            chk("tab_accepted", took, 1);
        end
        use_tab = 0;
        drain(3);
        chk_lat = 0;

        // Backpressure: six beats offered while the consumer stalls for five cycles.
        for (int i = 0; i < 6; i++) bpd[i] = {4{8'(i + 1)}};
        bi = 0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) chk("bp_in_ready_low", o_rdy[0], 0);
            if (c == 2) begin
                chk("bp_out_valid", o_vld[0], 1);
                held = res_a;
            end
            if (c > 2) chk("bp_res_stable", res_a, held);
            cyc(1'b1, bpd[bi < 6 ? bi : 5], 35'd0, bi != 0, 1'b0);
            if (took) bi++;
        end
        chk("bp_accepts", bi, 2);
        for (int c = 0; c < 20 && bi < 6; c++) begin
            cyc(1'b1, bpd[bi], 35'd0, 1'b1, 1'b1);
            if (took) bi++;
        end
        chk("bp_total_accepts", bi, 6);
        drain(4);

        // Asynchronous reset with both stages full and accumulator at 500.
        cyc(1'b1, {4{8'd125}}, 35'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'h01010101, 35'd0, 1'b1, 1'b0);
        chk("full_out_valid", o_vld[0], 1);
        chk("full_out_res", res_a, 500);
        chk("full_in_ready", o_rdy[0], 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", o_vld[0], 0);
        chk("async_out_res", res_a, 0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", o_rdy[0], 1);
        cyc(1'b1, 32'h00000001, 35'd0, 1'b1, 1'b1);
        cyc(1'b0, 32'd0, 35'd0, 1'b0, 1'b1);
        chk("post_rst_res", res_a, 1);
        drain(3);

        // Random traffic against the reference model on all instances.
        acc_cnt = 0;
        for (int c = 0; c < 40000 && acc_cnt < 10000; c++) begin
            rnd = {$urandom, $urandom};
            cyc($urandom_range(0, 9) < 7, $urandom, rnd[34:0], 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 7);
            if (took) acc_cnt++;
        end
        chk("rand_beats", acc_cnt, 10000);
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
